// File: rtl/seg7_scan_mux.sv
// Three-digit multiplexed 7-segment driver with a frame-stable shadow value,
// inter-digit blanking gap and optional leading-zero suppression.
module seg7_scan_mux #(
    parameter int REFRESH_DIV    = 16384,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] digits_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [2:0]  transistor,
    output logic [6:0]  d7sp,
    output logic        frame_start
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    // Pin polarity masks; internal logic is always active-high.
    localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [2:0] SEL_XOR = (SEL_ACTIVE_LOW != 0) ? 3'h7 : 3'h0;

    logic [0:0]    state_r,   state_s;
    logic [1:0]    idx_r,     idx_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic [11:0]   shadow_r,  shadow_s;
    logic [11:0]   staging_r, staging_s;
    logic          pending_r, pending_s;
    logic          frame_edge_s;
    logic [3:0]    digit_s;
    logic          blank_s;
    logic [6:0]    seg_s;
    logic [2:0]    sel_s;
    logic [6:0]    seg_r;
    logic [2:0]    sel_r;
    logic          fs_r;

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b1000000;
        endcase
        return seg;
    endfunction

    // Next-state, load/shadow handoff and next output values.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        shadow_s     = shadow_r;
        staging_s    = staging_r;
        pending_s    = pending_r;
        frame_edge_s = 1'b0;

        if (load) begin
            staging_s = digits_in;
            pending_s = 1'b1;
        end else begin
            staging_s = staging_r;
        end

        case (state_r)
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s      = ST_SHOW;
                    cnt_s        = '0;
                    idx_s        = (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
                    frame_edge_s = (idx_r == 2'd2);
                end else begin
                    state_s = ST_BLANK;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = '0;
                idx_s   = 2'd2;
            end
        endcase

        // Shadow only changes at the frame boundary so a frame never tears.
        if (frame_edge_s && (load || pending_r)) begin
            shadow_s  = load ? digits_in : staging_r;
            pending_s = 1'b0;
        end else begin
            shadow_s = shadow_r;
        end

        case (idx_s)
            2'd0:    digit_s = shadow_s[3:0];
            2'd1:    digit_s = shadow_s[7:4];
            2'd2:    digit_s = shadow_s[11:8];
            default: digit_s = 4'd0;
        endcase

        blank_s = lz_en && (((idx_s == 2'd2) && (shadow_s[11:8] == 4'd0)) ||
                            ((idx_s == 2'd1) && (shadow_s[11:4] == 8'd0)));

        if (state_s == ST_SHOW) begin
            sel_s = 3'b001 << idx_s;
            seg_s = blank_s ? 7'b0000000 : seg_decode(digit_s);
        end else begin
            sel_s = 3'b000;
            seg_s = 7'b0000000;
        end
    end

    // State, data and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_BLANK;
            idx_r     <= 2'd2;
            cnt_r     <= '0;
            shadow_r  <= 12'h000;
            staging_r <= 12'h000;
            pending_r <= 1'b0;
            sel_r     <= SEL_XOR;
            seg_r     <= SEG_XOR;
            fs_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            shadow_r  <= shadow_s;
            staging_r <= staging_s;
            pending_r <= pending_s;
            sel_r     <= sel_s ^ SEL_XOR;
            seg_r     <= seg_s ^ SEG_XOR;
            fs_r      <= frame_edge_s;
        end
    end

    assign transistor  = sel_r;
    assign d7sp        = seg_r;
    assign frame_start = fs_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a frame-position model predicts every
// output cycle, expectations are queued on drive and popped after the edge.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] digits_in;
    logic        load;
    logic        lz_en;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    int          pos = 0;
    int          cyc_no = 0;
    logic [11:0] m_shadow  = 12'h000;
    logic [11:0] m_staging = 12'h000;
    logic        m_pending = 1'b0;
    logic        lz_lvl    = 1'b0;
    string       phase     = "init";
    logic [10:0] exp_q[$];

    seg7_scan_mux #(
        .REFRESH_DIV   (4),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(0),
        .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .lz_en      (lz_en),
        .transistor (transistor),
        .d7sp       (d7sp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got sel=%b seg=%b fs=%b expected sel=%b seg=%b fs=%b",
                     tag, cyc_no, got[10:8], got[7:1], got[0], exp[10:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [0:9];
        tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
        if (v > 4'd9) return 7'b1000000;
        else          return tbl[v];
    endfunction

    // Frame of 18: positions 2-5 units, 8-11 tens, 14-17 hundreds, rest blank.
    function automatic logic [10:0] model_out(input int p, input logic [11:0] sh, input logic lz);
        int          grp;
        logic [3:0]  dig;
        logic        blk;
        logic [2:0]  sel;
        logic [6:0]  seg;
        grp = p / 6;
        if ((p % 6) < 2) return 11'd0;
        dig = sh[grp*4 +: 4];
        blk = lz && (((grp == 2) && (sh[11:8] == 4'd0)) || ((grp == 1) && (sh[11:4] == 8'd0)));
        sel = 3'b001 << grp;
        seg = blk ? 7'b0000000 : ref_seg(dig);
        return {sel, seg, (p == 2)};
    endfunction

    task automatic cyc(input logic r, input logic ld, input logic [11:0] din);
        logic [10:0] got;
        logic [10:0] exp;
        rst       = r;
        load      = ld;
        digits_in = din;
        lz_en     = lz_lvl;
        if (r) begin
            pos       = 0;
            m_shadow  = 12'h000;
            m_staging = 12'h000;
            m_pending = 1'b0;
            exp_q.push_back(11'd0);
        end else begin
            pos = (pos + 1) % 18;
            if (ld) begin
                m_staging = din;
                m_pending = 1'b1;
            end
            if ((pos == 2) && m_pending) begin
                m_shadow  = m_staging;
                m_pending = 1'b0;
            end
            exp_q.push_back(model_out(pos, m_shadow, lz_lvl));
        end
        @(posedge clk);
        #1;
        cyc_no++;
        got = {transistor, d7sp, frame_start};
        if (exp_q.size() == 0) begin
            check_val({phase, "_q_empty"}, got, 11'h7ff ^ got);
        end else begin
            exp = exp_q.pop_front();
            check_val(phase, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h000);
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 18 && pos != target; i++) cyc(1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = 12'h000; lz_en = 1'b0;

        phase = "reset";
        cyc(1'b1, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 12'h000);

        phase = "startup";
        idle(40);

        phase = "load_mid";
        run_until(9);
        cyc(1'b0, 1'b1, 12'h123);
        run_until(1);
        phase = "show_123";
        idle(18);

        phase = "lz_007";
        lz_lvl = 1'b1;
        cyc(1'b0, 1'b1, 12'h007);
        run_until(1);
        idle(18);
        phase = "lz_070";
        cyc(1'b0, 1'b1, 12'h070);
        run_until(1);
        idle(18);

        phase = "dash_a5f";
        lz_lvl = 1'b0;
        cyc(1'b0, 1'b1, 12'h999);
        cyc(1'b0, 1'b1, 12'ha5f);
        run_until(1);
        idle(18);

        phase = "load_edge";
        run_until(1);
        cyc(1'b0, 1'b1, 12'h456);
        idle(17);

        phase = "rst_mid";
        cyc(1'b0, 1'b1, 12'h123);
        run_until(1);
        idle(1);
        run_until(9);
        cyc(1'b0, 1'b1, 12'h999);
        cyc(1'b1, 1'b0, 12'h000);
        phase = "restart";
        idle(40);

        if (exp_q.size() != 0) check_val("q_leftover", 11'(exp_q.size()), 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
